// File: rtl/sum_ascii_tx.sv
// Converts a captured add/subtract result to ASCII: [sign] tens ones EOL on a valid/ready stream.
// Optional build macro LEADING_ZERO_SUPPRESS_EN drops the tens digit when it is zero.
module sum_ascii_tx #(
  parameter int          DATA_W   = 5,
  parameter logic [7:0]  EOL_CHAR = 8'h0A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_s,
  input  logic              in_c5,
  input  logic              in_e,
  input  logic              in_signed,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              busy
);

  localparam int VW = DATA_W + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CONV = 3'd1,
    S_SIGN = 3'd2,
    S_TENS = 3'd3,
    S_ONES = 3'd4,
    S_EOL  = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [VW-1:0]   rem_q, rem_d;
  logic [2:0]      tens_q, tens_d;
  logic            neg_q, neg_d;
  logic            signed_q, signed_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;

  logic [VW-1:0]   value_s;
  logic [VW-1:0]   mag_s;
  logic            skip_tens_s;
  logic            tx_fire_s;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  // Capture-side value formation: overflowed signed results use the carry as the true sign bit.
  always_comb begin
    if (in_signed && !in_e) begin
      value_s = {in_s[DATA_W-1], in_s};
    end else begin
      value_s = {in_c5, in_s};
    end
    if (in_signed && value_s[VW-1]) begin
      mag_s = -value_s;
    end else begin
      mag_s = value_s;
    end
  end

  // Tens-digit skip decision for the optional suppression build.
  always_comb begin
`ifdef LEADING_ZERO_SUPPRESS_EN
    skip_tens_s = (tens_q == 3'd0);
`else
    skip_tens_s = 1'b0;
`endif
  end

  // Next-state, conversion step and registered output byte selection.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    tens_d     = tens_q;
    neg_d      = neg_q;
    signed_d   = signed_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_fire_s  = tx_valid_q & tx_ready;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d  = S_CONV;
          rem_d    = mag_s;
          tens_d   = 3'd0;
          neg_d    = in_signed & value_s[VW-1];
          signed_d = in_signed;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        if (rem_q >= VW'(10)) begin
          rem_d  = rem_q - VW'(10);
          tens_d = tens_q + 3'd1;
        end else if (signed_q) begin
          state_d    = S_SIGN;
          tx_valid_d = 1'b1;
          tx_data_d  = neg_q ? 8'h2D : 8'h2B;
        end else if (skip_tens_s) begin
          state_d    = S_ONES;
          tx_valid_d = 1'b1;
          tx_data_d  = ascii_digit(rem_q[3:0]);
        end else begin
          state_d    = S_TENS;
          tx_valid_d = 1'b1;
          tx_data_d  = ascii_digit({1'b0, tens_q});
        end
      end
      S_SIGN: begin
        if (tx_fire_s && skip_tens_s) begin
          state_d   = S_ONES;
          tx_data_d = ascii_digit(rem_q[3:0]);
        end else if (tx_fire_s) begin
          state_d   = S_TENS;
          tx_data_d = ascii_digit({1'b0, tens_q});
        end else begin
          state_d = S_SIGN;
        end
      end
      S_TENS: begin
        if (tx_fire_s) begin
          state_d   = S_ONES;
          tx_data_d = ascii_digit(rem_q[3:0]);
        end else begin
          state_d = S_TENS;
        end
      end
      S_ONES: begin
        if (tx_fire_s) begin
          state_d   = S_EOL;
          tx_data_d = EOL_CHAR;
        end else begin
          state_d = S_ONES;
        end
      end
      S_EOL: begin
        if (tx_fire_s) begin
          state_d    = S_IDLE;
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
        end else begin
          state_d = S_EOL;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end
    endcase

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      tens_q     <= 3'd0;
      neg_q      <= 1'b0;
      signed_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      tens_q     <= tens_d;
      neg_q      <= neg_d;
      signed_q   <= signed_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_sum_ascii_tx.sv
// Self-checking bench for sum_ascii_tx: fixed vectors, random results with random backpressure,
// stall, mid-stream reset and busy-time input checks against an arithmetic reference model.
module tb_sum_ascii_tx;
  localparam int DATA_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_s;
  logic              in_c5;
  logic              in_e;
  logic              in_signed;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic              busy;

  int checks   = 0;
  int failures = 0;
  byte unsigned exp_q[$];
  byte unsigned obs_q[$];
  int obs_lat;

  sum_ascii_tx #(.DATA_W(DATA_W), .EOL_CHAR(8'h0A)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_c5(in_c5), .in_e(in_e), .in_signed(in_signed),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: integer interpretation of the result, then decimal digits via / and %.
  function automatic int model(input logic [4:0] s, input logic c5, input logic e, input logic sg);
    int v;
    int mag;
    int tens;
    exp_q.delete();
    if (!sg) begin
      v = int'(c5) * 32 + int'(s);
    end else if (e) begin
      v = int'(c5) * 32 + int'(s);
      if (v >= 32) v = v - 64;
    end else begin
      v = int'(s);
      if (v >= 16) v = v - 32;
    end
    mag  = (v < 0) ? -v : v;
    tens = mag / 10;
    if (sg) exp_q.push_back((v < 0) ? 8'h2D : 8'h2B);
`ifdef LEADING_ZERO_SUPPRESS_EN
    if (tens != 0) exp_q.push_back(8'(8'h30 + tens));
`else
    exp_q.push_back(8'(8'h30 + tens));
`endif
    exp_q.push_back(8'(8'h30 + mag % 10));
    exp_q.push_back(8'h0A);
    return tens;
  endfunction

  task automatic accept(input logic [4:0] s, input logic c5, input logic e, input logic sg);
    for (int i = 0; i < 50 && in_ready !== 1'b1; i++) step();
    if (in_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    in_s = s; in_c5 = c5; in_e = e; in_signed = sg; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic collect(input int rdy_pct);
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       done = 1'b0;
    obs_q.delete();
    obs_lat = -1;
    for (int cyc = 1; cyc < 300 && !done; cyc++) begin
      tx_ready = ($urandom_range(99) < rdy_pct);
      if (prev_hold) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          failures++;
          $display("FAIL hold_stable: valid=%b data=%h required valid=1 data=%h", tx_valid, tx_data, prev_data);
        end
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_flags: in_ready=%b busy=%b required 0/1", in_ready, busy);
      end
      if (tx_valid === 1'b1 && obs_lat < 0) obs_lat = cyc;
      if (tx_valid === 1'b1 && tx_ready) begin
        obs_q.push_back(tx_data);
        if (tx_data == 8'h0A) done = 1'b1;
      end
      prev_hold = (tx_valid === 1'b1) && !tx_ready;
      prev_data = tx_data;
      step();
    end
    tx_ready = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL collect_timeout: no EOL seen, got %0d bytes required %0d", obs_q.size(), exp_q.size());
    end else if (in_ready !== 1'b1 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_eol: in_ready=%b tx_valid=%b required 1/0", in_ready, tx_valid);
    end
  endtask

  task automatic test_vector(input string name, input logic [4:0] s, input logic c5,
                             input logic e, input logic sg, input int pct);
    int tens;
    tens = model(s, c5, e, sg);
    accept(s, c5, e, sg);
    collect(pct);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s len: got %0d required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s byte%0d: got %h required %h", name, i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_lat != tens + 2) begin
      failures++;
      $display("FAIL %s latency: got %0d required %0d", name, obs_lat, tens + 2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; tx_ready = 1'b0;
    in_s = '0; in_c5 = 1'b0; in_e = 1'b0; in_signed = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b vld=%b data=%h busy=%b required 1 0 00 0", in_ready, tx_valid, tx_data, busy);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_plan();
    test_vector("neg5",      5'b11011, 1'b1, 1'b0, 1'b1, 100);
    test_vector("ovf_m30",   5'b00010, 1'b1, 1'b1, 1'b1, 100);
    test_vector("u15p15",    5'b11110, 1'b0, 1'b0, 1'b0, 100);
    test_vector("umax63",    5'b11111, 1'b1, 1'b0, 1'b0, 100);
    test_vector("s_zero",    5'b00000, 1'b0, 1'b0, 1'b1, 100);
    test_vector("u_zero",    5'b00000, 1'b0, 1'b0, 1'b0, 100);
    test_vector("s_min_ovf", 5'b00000, 1'b1, 1'b1, 1'b1, 100);
    test_vector("s_m16",     5'b10000, 1'b0, 1'b0, 1'b1, 100);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      test_vector("random", 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(100, 30));
    end
  endtask

  task automatic test_backpressure();
    int tens;
    tens = model(5'b11011, 1'b1, 1'b0, 1'b1);
    accept(5'b11011, 1'b1, 1'b0, 1'b1);
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && tx_valid !== 1'b1; i++) step();
    step();
    for (int i = 0; i < 3; i++) begin
      tx_ready = 1'b0;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_q[1] || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: vld=%b data=%h rdy=%b required 1 %h 0", i, tx_valid, tx_data, in_ready, exp_q[1]);
      end
      step();
    end
    tx_ready = 1'b1;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== exp_q[1]) begin
      failures++;
      $display("FAIL bp_release: vld=%b data=%h required 1 %h", tx_valid, tx_data, exp_q[1]);
    end
    step();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== exp_q[2]) begin
      failures++;
      $display("FAIL bp_next: vld=%b data=%h required 1 %h", tx_valid, tx_data, exp_q[2]);
    end
    for (int i = 0; i < 10 && !(tx_valid === 1'b1 && tx_data == 8'h0A); i++) step();
    step();
    tx_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || tens != 0) begin
      failures++;
      $display("FAIL bp_idle: in_ready=%b tens=%0d required 1 0", in_ready, tens);
    end
  endtask

  task automatic test_mid_reset();
    logic seen = 1'b0;
    accept(5'b11011, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 30 && !seen; i++) begin
      if (tx_valid === 1'b1 && tx_data == 8'h35) begin
        tx_ready = 1'b0;
        seen = 1'b1;
      end else begin
        tx_ready = 1'b1;
        step();
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL mid_reset_ones: ones byte never pending, data=%h required 35", tx_data);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_async: vld=%b rdy=%b busy=%b required 0 1 0", tx_valid, in_ready, busy);
    end
    #1 rst = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (tx_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_quiet: tx_valid=%b required 0", tx_valid);
      end
    end
    tx_ready = 1'b0;
    test_vector("after_rst_p7", 5'b00111, 1'b0, 1'b0, 1'b1, 100);
  endtask

  task automatic test_busy_ignore();
    void'(model(5'b11110, 1'b0, 1'b0, 1'b0));
    accept(5'b11110, 1'b0, 1'b0, 1'b0);
    in_s = 5'b00001; in_signed = 1'b1; in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    collect(100);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL busy_ignore len: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL busy_ignore byte%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (tx_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL busy_not_queued: vld=%b rdy=%b required 0 1", tx_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_plan();
    test_backpressure();
    test_busy_ignore();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sum_ascii_tx.md
Name: sum_ascii_tx

Overview:
Formats the add/subtract datapath result into ASCII characters, one byte per transfer on a valid/ready stream. It performs the opposite conversion to the console input path, which turns decimal keystrokes into binary operands. Each result is captured as S, C5 and E, plus a signed/unsigned flag. The block converts the value to decimal with an iterative subtract-10 loop, then transmits an optional sign, the tens digit, the ones digit and an end-of-line byte.

Parameters:
DATA_W, 5, result width of S; legal range 4..5, so the magnitude is at most 63 and two digits are enough.
EOL_CHAR, 8'h0A, byte sent after the ones digit.

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  result present
in_ready  output  1  block can accept; high only in IDLE
in_s  input  DATA_W  sum bits S
in_c5  input  1  carry out of the MSB stage
in_e  input  1  signed overflow flag (C4 xor C5)
in_signed  input  1  1 = two's-complement interpretation, 0 = unsigned
tx_valid  output  1  tx_data holds a character
tx_ready  input  1  downstream accepts
tx_data  output  8  ASCII byte
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async assert, released synchronously to clk):
  - state = IDLE; in_ready = 1; tx_valid = 0; tx_data = 8'h00; busy = 0.
  - Internal tens and remainder registers = 0.
- Acceptance:
  - A transfer occurs on a cycle with in_valid & in_ready.
  - The inputs are captured on that edge and are ignored at all other times.
- Value formed at capture (DATA_W+1 bits):
  - Unsigned: value = {in_c5, in_s}, giving 0..2^(DATA_W+1)-1.
  - Signed, E=0: value = in_s sign-extended by one bit.
  - Signed, E=1: value = {in_c5, in_s}, the corrected 6-bit result.
  - Signed: neg = value MSB; magnitude = neg ? -value : value, held unsigned (max 32).
- States: IDLE -> CONV -> [SIGN] -> TENS -> ONES -> EOL -> IDLE.
- CONV, one step per cycle:
  - If rem >= 10: rem -= 10 and tens += 1.
  - Otherwise exit CONV. The exit goes to SIGN if in_signed was captured as 1, else to TENS.
  - CONV therefore lasts tens+1 cycles.
- Output states:
  - tx_valid is registered and rises on the first cycle of each output state.
  - SIGN sends '-' (8'h2D) if neg, otherwise '+' (8'h2B).
  - TENS sends 8'h30+tens; ONES sends 8'h30+rem; EOL sends EOL_CHAR.
- Output handshake:
  - A state advances only on tx_valid & tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data must hold stable.
  - tx_valid never drops without a transfer, except on reset.
- Throughput: back-to-back bytes are allowed; with tx_ready held high, one byte moves per cycle.
  - After the EOL transfer, the block is in IDLE with in_ready=1 on the next cycle.
- Boundary conditions:
  - Magnitude 0 sends "+00" in signed mode and "00" in unsigned mode.
  - in_valid while busy is neither captured nor queued; the upstream must hold its valid.
  - tx_ready high with tx_valid low has no effect.
- Reset mid-operation: all state is abandoned immediately, nothing further is emitted, and the block returns to IDLE.

Optional Feature:
LEADING_ZERO_SUPPRESS_EN
- Defined: TENS is skipped when tens==0.
  - Example: "+5\n" instead of "+05\n".
  - Zero is sent as the single digit '0'.
- Undefined: two digits are always sent.

Test Plan:
- Signed -5: in_signed=1, in_s=5'b11011, in_c5=1, in_e=0.
  -> bytes 2D, 30, 35, 0A.
  -> tx_valid first rises 2 cycles after acceptance (CONV lasts 1 cycle).
- Signed overflow: in_s=5'b00010, in_c5=1, in_e=1, signed (value -30).
  -> 2D, 33, 30, 0A.
  -> CONV lasts 4 cycles.
- Unsigned 15+15: in_s=5'b11110, in_c5=0.
  -> 33, 30, 0A; no sign byte.
- Unsigned maximum: in_s=5'b11111, in_c5=1 (value 63).
  -> 36, 33, 0A.
- Backpressure: during the signed -5 case, hold tx_ready=0 for 3 cycles on the TENS byte.
  -> tx_data stays 8'h30 and tx_valid stays 1.
  -> in_ready stays 0; the next byte follows one cycle after tx_ready=1.
- Reset mid-stream: assert rst while the ONES byte is pending.
  -> tx_valid=0 and in_ready=1 immediately.
  -> a new input of +7 (in_s=5'b00111, signed) yields 2B, 30, 37, 0A.
